// File: rtl/core_fetch_prefetch.sv
// Prefetching instruction-fetch unit: a DEPTH-entry {pc, instr, err} queue filled
// from imem independently of EXEC consumption, flushed by CSR/EXEC redirects.
module core_fetch_prefetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CW           = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  input  logic          interrupt_valid,
  input  logic          pc_csr_valid,
  input  logic [31:0]   pc_csr,
  input  logic          pc_new_valid,
  input  logic [31:0]   pc_new,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus_4,
  output logic          ex_instr_access_fault,
  output logic [CW-1:0] occupancy,
  output logic          imem_valid,
  input  logic          imem_ready,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_err
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  entry_t        queue_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          err_stall_q, err_stall_d;

  logic          redirect_s;
  logic [31:0]   redirect_raw_s;
  logic [31:0]   redirect_target_s;
  logic          fetch_done_s;
  logic          dequeue_s;
  entry_t        head_s;

  assign redirect_s        = pc_csr_valid | pc_new_valid;
  assign redirect_raw_s    = pc_csr_valid ? pc_csr : pc_new;
  assign redirect_target_s = {redirect_raw_s[31:2], 2'b00};

  // rst_n gates the request so imem sees no request while reset is held
  assign imem_valid   = rst_n & fetch_en & ~interrupt_valid & ~redirect_s &
                        ~err_stall_q & (occ_q < DEPTH_C);
  assign imem_addr    = fetch_pc_q;
  assign fetch_done_s = imem_valid & imem_ready;
  assign dequeue_s    = instr_valid & instr_ready;

  assign head_s                = queue_q[head_q];
  assign instr_valid           = (occ_q != {CW{1'b0}});
  assign instr                 = head_s.instr;
  assign pc                    = head_s.pc;
  assign pc_plus_4             = head_s.pc + 32'd4;
  assign ex_instr_access_fault = head_s.err;
  assign occupancy             = occ_q;

  // Next-state: a redirect flushes everything and retargets fetch_pc
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    fetch_pc_d  = fetch_pc_q;
    err_stall_d = err_stall_q;
    if (redirect_s) begin
      head_d      = {PW{1'b0}};
      tail_d      = {PW{1'b0}};
      occ_d       = {CW{1'b0}};
      fetch_pc_d  = redirect_target_s;
      err_stall_d = 1'b0;
    end else begin
      if (fetch_done_s) begin
        tail_d      = tail_q + 1'b1;
        fetch_pc_d  = fetch_pc_q + 32'd4;
        err_stall_d = err_stall_q | imem_err;
      end else begin
        tail_d      = tail_q;
        fetch_pc_d  = fetch_pc_q;
        err_stall_d = err_stall_q;
      end
      if (dequeue_s) begin
        head_d = head_q + 1'b1;
      end else begin
        head_d = head_q;
      end
      case ({fetch_done_s, dequeue_s})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      occ_q       <= {CW{1'b0}};
      fetch_pc_q  <= RESET_VECTOR;
      err_stall_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      fetch_pc_q  <= fetch_pc_d;
      err_stall_q <= err_stall_d;
    end
  end

  // Queue storage is deliberately unreset; occupancy qualifies its contents
  always_ff @(posedge clk) begin
    if (fetch_done_s) begin
      queue_q[tail_q] <= '{pc: fetch_pc_q, instr: imem_rdata, err: imem_err};
    end
  end

endmodule

// File: tb/tb_core_fetch_prefetch.sv
// Directed bench for core_fetch_prefetch: one instance at RESET_VECTOR 0, one at
// 0xFFFF_FFF8 for address wrap and mid-stream reset.
module tb_core_fetch_prefetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // instance A
  logic        rst_a_n, a_fetch_en, a_int, a_csr_v, a_new_v, a_instr_ready, a_imem_ready, a_err_en;
  logic [31:0] a_csr, a_new;
  logic        a_instr_valid, a_fault, a_imem_valid, a_imem_err;
  logic [31:0] a_instr, a_pc, a_pc_plus_4, a_imem_addr, a_imem_rdata;
  logic [2:0]  a_occ;

  assign a_imem_rdata = a_imem_addr ^ KEY;
  assign a_imem_err   = a_err_en & (a_imem_addr == 32'h0000_0008);

  core_fetch_prefetch #(.RESET_VECTOR(32'h0000_0000), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .fetch_en(a_fetch_en), .interrupt_valid(a_int),
    .pc_csr_valid(a_csr_v), .pc_csr(a_csr), .pc_new_valid(a_new_v), .pc_new(a_new),
    .instr_valid(a_instr_valid), .instr_ready(a_instr_ready), .instr(a_instr),
    .pc(a_pc), .pc_plus_4(a_pc_plus_4), .ex_instr_access_fault(a_fault),
    .occupancy(a_occ), .imem_valid(a_imem_valid), .imem_ready(a_imem_ready),
    .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata), .imem_err(a_imem_err)
  );

  // instance B
  logic        rst_b_n, b_fetch_en, b_instr_ready, b_imem_ready, b_zero;
  logic [31:0] b_zero32;
  logic        b_instr_valid, b_fault, b_imem_valid;
  logic [31:0] b_instr, b_pc, b_pc_plus_4, b_imem_addr, b_imem_rdata;
  logic [2:0]  b_occ;

  assign b_imem_rdata = b_imem_addr ^ KEY;

  core_fetch_prefetch #(.RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .fetch_en(b_fetch_en), .interrupt_valid(b_zero),
    .pc_csr_valid(b_zero), .pc_csr(b_zero32), .pc_new_valid(b_zero), .pc_new(b_zero32),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .instr(b_instr),
    .pc(b_pc), .pc_plus_4(b_pc_plus_4), .ex_instr_access_fault(b_fault),
    .occupancy(b_occ), .imem_valid(b_imem_valid), .imem_ready(b_imem_ready),
    .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata), .imem_err(b_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; a_fetch_en = 1'b1; a_int = 1'b0; a_csr_v = 1'b0; a_new_v = 1'b0;
    a_csr = 32'h0; a_new = 32'h0; a_instr_ready = 1'b0; a_imem_ready = 1'b1; a_err_en = 1'b0;
    rst_b_n = 1'b0; b_fetch_en = 1'b0; b_instr_ready = 1'b0; b_imem_ready = 1'b0;
    b_zero = 1'b0; b_zero32 = 32'h0;
    #2;
    n_vec++; if (a_occ !== 3'd0) begin n_err++; $display("FAIL rst_occ: got %0d expected 0", a_occ); end
    n_vec++; if (a_instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_instr_valid: got %b expected 0", a_instr_valid); end
    n_vec++; if (a_imem_valid !== 1'b0) begin n_err++; $display("FAIL rst_imem_valid: got %b expected 0", a_imem_valid); end
    tick();
    rst_a_n = 1'b1;
    #1;
    n_vec++; if (a_imem_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_imem_valid: got %b expected 1", a_imem_valid); end
    n_vec++; if (a_imem_addr !== 32'h0) begin n_err++; $display("FAIL post_rst_addr: got %h expected 00000000", a_imem_addr); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (a_imem_addr !== 32'(4 * i)) begin n_err++; $display("FAIL fill_addr%0d: got %h expected %h", i, a_imem_addr, 32'(4 * i)); end
      n_vec++; if (a_occ !== 3'(i)) begin n_err++; $display("FAIL fill_occ%0d: got %0d expected %0d", i, a_occ, i); end
      tick();
    end
    n_vec++; if (a_imem_valid !== 1'b0) begin n_err++; $display("FAIL full_imem_valid: got %b expected 0", a_imem_valid); end
    n_vec++; if (a_occ !== 3'd4) begin n_err++; $display("FAIL full_occ: got %0d expected 4", a_occ); end
    n_vec++; if (a_pc !== 32'h0) begin n_err++; $display("FAIL full_head_pc: got %h expected 00000000", a_pc); end
    n_vec++; if (a_pc_plus_4 !== 32'h4) begin n_err++; $display("FAIL full_pc_plus_4: got %h expected 00000004", a_pc_plus_4); end
    n_vec++; if (a_instr !== KEY) begin n_err++; $display("FAIL full_head_instr: got %h expected %h", a_instr, KEY); end
  endtask

  task automatic test_full_resume();
    a_instr_ready = 1'b1;
    #1;
    n_vec++; if (a_imem_valid !== 1'b0) begin n_err++; $display("FAIL full_with_ready: got %b expected 0", a_imem_valid); end
    tick();
    a_instr_ready = 1'b0;
    #1;
    n_vec++; if (a_occ !== 3'd3) begin n_err++; $display("FAIL resume_occ: got %0d expected 3", a_occ); end
    n_vec++; if (a_pc !== 32'h4) begin n_err++; $display("FAIL resume_head_pc: got %h expected 00000004", a_pc); end
    n_vec++; if (a_imem_valid !== 1'b1 || a_imem_addr !== 32'h10) begin n_err++; $display("FAIL resume_req: got v=%b a=%h expected v=1 a=00000010", a_imem_valid, a_imem_addr); end
  endtask

  task automatic test_redirect();
    a_new_v = 1'b1; a_new = 32'h0000_0103;
    #1;
    n_vec++; if (a_imem_valid !== 1'b0) begin n_err++; $display("FAIL redir_cycle_req: got %b expected 0", a_imem_valid); end
    tick();
    a_new_v = 1'b0;
    #1;
    n_vec++; if (a_occ !== 3'd0 || a_instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got occ=%0d v=%b expected occ=0 v=0", a_occ, a_instr_valid); end
    n_vec++; if (a_imem_valid !== 1'b1 || a_imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_target: got v=%b a=%h expected v=1 a=00000100", a_imem_valid, a_imem_addr); end
  endtask

  task automatic test_stream();
    a_instr_ready = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      n_vec++; if (a_instr_valid !== 1'b1 || a_occ !== 3'd1) begin n_err++; $display("FAIL stream_occ%0d: got v=%b occ=%0d expected v=1 occ=1", k, a_instr_valid, a_occ); end
      n_vec++; if (a_pc !== 32'h100 + 32'(4 * k)) begin n_err++; $display("FAIL stream_pc%0d: got %h expected %h", k, a_pc, 32'h100 + 32'(4 * k)); end
      n_vec++; if (a_instr !== ((32'h100 + 32'(4 * k)) ^ KEY)) begin n_err++; $display("FAIL stream_instr%0d: got %h expected %h", k, a_instr, (32'h100 + 32'(4 * k)) ^ KEY); end
      tick();
    end
  endtask

  task automatic test_csr_priority();
    a_csr_v = 1'b1; a_csr = 32'h0000_0800; a_new_v = 1'b1; a_new = 32'h0000_0200;
    #1;
    n_vec++; if (a_imem_valid !== 1'b0) begin n_err++; $display("FAIL prio_cycle_req: got %b expected 0", a_imem_valid); end
    tick();
    a_csr_v = 1'b0; a_new_v = 1'b0; a_instr_ready = 1'b0;
    #1;
    n_vec++; if (a_occ !== 3'd0 || a_imem_addr !== 32'h800) begin n_err++; $display("FAIL prio_target: got occ=%0d a=%h expected occ=0 a=00000800", a_occ, a_imem_addr); end
    tick();
    n_vec++; if (a_occ !== 3'd1 || a_pc !== 32'h800 || a_pc_plus_4 !== 32'h804) begin n_err++; $display("FAIL prio_head: got occ=%0d pc=%h p4=%h expected occ=1 pc=00000800 p4=00000804", a_occ, a_pc, a_pc_plus_4); end
  endtask

  task automatic test_err();
    a_err_en = 1'b1; a_new_v = 1'b1; a_new = 32'h0;
    #1;
    tick();
    a_new_v = 1'b0;
    #1;
    tick();
    tick();
    n_vec++; if (a_imem_valid !== 1'b1 || a_imem_addr !== 32'h8) begin n_err++; $display("FAIL err_req8: got v=%b a=%h expected v=1 a=00000008", a_imem_valid, a_imem_addr); end
    tick();
    n_vec++; if (a_occ !== 3'd3 || a_imem_valid !== 1'b0 || a_imem_addr !== 32'hC) begin n_err++; $display("FAIL err_stall: got occ=%0d v=%b a=%h expected occ=3 v=0 a=0000000c", a_occ, a_imem_valid, a_imem_addr); end
    a_instr_ready = 1'b1;
    tick();
    n_vec++; if (a_pc !== 32'h4 || a_fault !== 1'b0) begin n_err++; $display("FAIL err_clean_entry: got pc=%h f=%b expected pc=00000004 f=0", a_pc, a_fault); end
    tick();
    n_vec++; if (a_pc !== 32'h8 || a_fault !== 1'b1 || a_instr_valid !== 1'b1) begin n_err++; $display("FAIL err_entry: got pc=%h f=%b v=%b expected pc=00000008 f=1 v=1", a_pc, a_fault, a_instr_valid); end
    n_vec++; if (a_imem_valid !== 1'b0) begin n_err++; $display("FAIL err_still_stalled: got %b expected 0", a_imem_valid); end
    tick();
    n_vec++; if (a_instr_valid !== 1'b0 || a_imem_valid !== 1'b0) begin n_err++; $display("FAIL err_drained: got v=%b req=%b expected v=0 req=0", a_instr_valid, a_imem_valid); end
    a_err_en = 1'b0; a_new_v = 1'b1; a_new = 32'h40; a_instr_ready = 1'b0;
    #1;
    tick();
    a_new_v = 1'b0;
    #1;
    n_vec++; if (a_imem_valid !== 1'b1 || a_imem_addr !== 32'h40) begin n_err++; $display("FAIL err_cleared: got v=%b a=%h expected v=1 a=00000040", a_imem_valid, a_imem_addr); end
  endtask

  task automatic test_gating();
    tick();
    tick();
    a_fetch_en = 1'b0; a_instr_ready = 1'b1;
    #1;
    n_vec++; if (a_imem_valid !== 1'b0) begin n_err++; $display("FAIL gate_fetch_en: got %b expected 0", a_imem_valid); end
    tick();
    n_vec++; if (a_occ !== 3'd1 || a_pc !== 32'h44) begin n_err++; $display("FAIL gate_drain: got occ=%0d pc=%h expected occ=1 pc=00000044", a_occ, a_pc); end
    a_fetch_en = 1'b1; a_int = 1'b1;
    #1;
    n_vec++; if (a_imem_valid !== 1'b0) begin n_err++; $display("FAIL gate_interrupt: got %b expected 0", a_imem_valid); end
    tick();
    n_vec++; if (a_occ !== 3'd0 || a_instr_valid !== 1'b0) begin n_err++; $display("FAIL gate_empty: got occ=%0d v=%b expected occ=0 v=0", a_occ, a_instr_valid); end
    a_int = 1'b0; a_imem_ready = 1'b0;
    #1;
    n_vec++; if (a_imem_valid !== 1'b1 || a_imem_addr !== 32'h48) begin n_err++; $display("FAIL gate_release: got v=%b a=%h expected v=1 a=00000048", a_imem_valid, a_imem_addr); end
    tick();
    n_vec++; if (a_occ !== 3'd0 || a_instr_valid !== 1'b0) begin n_err++; $display("FAIL empty_ignore_ready: got occ=%0d v=%b expected occ=0 v=0", a_occ, a_instr_valid); end
  endtask

  task automatic test_wrap();
    b_fetch_en = 1'b1; b_imem_ready = 1'b1; b_instr_ready = 1'b0;
    #1;
    n_vec++; if (b_imem_valid !== 1'b0) begin n_err++; $display("FAIL wrap_in_reset: got %b expected 0", b_imem_valid); end
    rst_b_n = 1'b1;
    #1;
    n_vec++; if (b_imem_valid !== 1'b1 || b_imem_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_first: got v=%b a=%h expected v=1 a=fffffff8", b_imem_valid, b_imem_addr); end
    tick();
    n_vec++; if (b_imem_addr !== 32'hFFFF_FFFC || b_occ !== 3'd1) begin n_err++; $display("FAIL wrap_second: got a=%h occ=%0d expected a=fffffffc occ=1", b_imem_addr, b_occ); end
    tick();
    n_vec++; if (b_imem_addr !== 32'h0 || b_occ !== 3'd2) begin n_err++; $display("FAIL wrap_third: got a=%h occ=%0d expected a=00000000 occ=2", b_imem_addr, b_occ); end
    tick();
    n_vec++; if (b_occ !== 3'd3 || b_pc !== 32'hFFFF_FFF8 || b_pc_plus_4 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_head0: got occ=%0d pc=%h p4=%h expected occ=3 pc=fffffff8 p4=fffffffc", b_occ, b_pc, b_pc_plus_4); end
    b_instr_ready = 1'b1; b_imem_ready = 1'b0;
    #1;
    tick();
    n_vec++; if (b_pc !== 32'hFFFF_FFFC || b_pc_plus_4 !== 32'h0 || b_instr !== (32'hFFFF_FFFC ^ KEY)) begin n_err++; $display("FAIL wrap_head1: got pc=%h p4=%h i=%h expected pc=fffffffc p4=00000000", b_pc, b_pc_plus_4, b_instr); end
    n_vec++; if (b_occ !== 3'd2) begin n_err++; $display("FAIL wrap_occ: got %0d expected 2", b_occ); end
  endtask

  task automatic test_reset_mid();
    b_imem_ready = 1'b1;
    #1;
    rst_b_n = 1'b0;
    #1;
    n_vec++; if (b_occ !== 3'd0 || b_imem_valid !== 1'b0 || b_instr_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset: got occ=%0d req=%b v=%b expected occ=0 req=0 v=0", b_occ, b_imem_valid, b_instr_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_resume();
    test_redirect();
    test_stream();
    test_csr_priority();
    test_err();
    test_gating();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
